// File: rtl/bounce_pkg.sv
// Shared constants, types and helpers for the bouncing-squares video demo.
// Timing is 640x480 active inside an 800x525 raster.
package bounce_pkg;

   localparam int H_RES  = 32'sd640;
   localparam int V_RES  = 32'sd480;
   localparam int LINE   = 32'sd800;
   localparam int SCREEN = 32'sd525;
   localparam int MAX_SQ = 32'sd4;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb4_t;

   localparam int    INIT_X [MAX_SQ] = '{32'sd40, 32'sd160, 32'sd280, 32'sd400};
   localparam int    INIT_Y [MAX_SQ] = '{32'sd40, 32'sd120, 32'sd200, 32'sd280};
   localparam rgb4_t COLOUR [MAX_SQ] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};
   localparam rgb4_t BG_COLOUR       = 12'h137;

   function automatic logic [7:0] dbl4(input logic [3:0] c);
      return {2{c}};
   endfunction

endpackage

// File: rtl/bounce_if.sv
// Video output bus of the bouncing-squares demo plus its pause control.
// The master side (the demo) drives pixels; the slave side drives pause.
interface bounce_if #(
   parameter int CORDW = 10
);
   logic             pause;
   logic [CORDW-1:0] sdl_sx;
   logic [CORDW-1:0] sdl_sy;
   logic             sdl_de;
   logic [7:0]       sdl_r;
   logic [7:0]       sdl_g;
   logic [7:0]       sdl_b;
   logic             frame;

   modport master (
      input  pause,
      output sdl_sx, sdl_sy, sdl_de, sdl_r, sdl_g, sdl_b, frame
   );

   modport slave (
      output pause,
      input  sdl_sx, sdl_sy, sdl_de, sdl_r, sdl_g, sdl_b, frame
   );
endinterface

// File: rtl/square_mover.sv
// One bouncing square: position/direction state, per-frame motion and
// the combinational hit test against the current raster position.
module square_mover
   import bounce_pkg::*;
#(
   parameter int CORDW   = 10,
   parameter int SQ_SIZE = 40,
   parameter int SPEED   = 2,
   parameter int INIT_X  = 40,
   parameter int INIT_Y  = 40
) (
   input  logic             clk_pix,
   input  logic             sim_rst_n,
   input  logic             tick,
   input  logic             pause,
   input  logic [CORDW-1:0] sx,
   input  logic [CORDW-1:0] sy,
   output logic             hit
);

   // One extra bit of headroom so pos+SPEED and pos+SQ_SIZE never wrap.
   localparam logic [CORDW:0]   X_LIM = (CORDW+1)'(H_RES - SQ_SIZE);
   localparam logic [CORDW:0]   Y_LIM = (CORDW+1)'(V_RES - SQ_SIZE);
   localparam logic [CORDW:0]   STEP  = (CORDW+1)'(SPEED);
   localparam logic [CORDW:0]   SIZE  = (CORDW+1)'(SQ_SIZE);
   localparam logic [CORDW-1:0] X0    = CORDW'(INIT_X);
   localparam logic [CORDW-1:0] Y0    = CORDW'(INIT_Y);

   logic [CORDW-1:0] x_r;
   logic [CORDW-1:0] y_r;
   logic             dx_r;
   logic             dy_r;
   logic [CORDW:0]   x_step_s;
   logic [CORDW:0]   y_step_s;
   logic [CORDW:0]   sx_w_s;
   logic [CORDW:0]   sy_w_s;
   logic [CORDW:0]   x_w_s;
   logic [CORDW:0]   y_w_s;

   // Returns {new_dir, new_pos}; reaching a wall clamps and reverses.
   function automatic logic [CORDW:0] axis_step(
      input logic [CORDW-1:0] pos,
      input logic             dir,
      input logic [CORDW:0]   lim
   );
      logic [CORDW:0] pos_w;
      logic [CORDW:0] tmp;
      logic [CORDW:0] res;
      pos_w = {1'b0, pos};
      if (dir) begin
         tmp = pos_w + STEP;
         if (tmp >= lim) begin
            res = {1'b0, lim[CORDW-1:0]};
         end else begin
            res = {1'b1, tmp[CORDW-1:0]};
         end
      end else begin
         tmp = pos_w - STEP;
         if (pos_w <= STEP) begin
            res = {1'b1, {CORDW{1'b0}}};
         end else begin
            res = {1'b0, tmp[CORDW-1:0]};
         end
      end
      return res;
   endfunction

   // Next-state candidates and the hit window test.
   always_comb begin
      x_step_s = axis_step(x_r, dx_r, X_LIM);
      y_step_s = axis_step(y_r, dy_r, Y_LIM);
      sx_w_s   = {1'b0, sx};
      sy_w_s   = {1'b0, sy};
      x_w_s    = {1'b0, x_r};
      y_w_s    = {1'b0, y_r};
      hit      = (sx_w_s >= x_w_s) && (sx_w_s < x_w_s + SIZE) &&
                 (sy_w_s >= y_w_s) && (sy_w_s < y_w_s + SIZE);
   end

   // Square state: moves once per unpaused animation tick.
   always_ff @(posedge clk_pix) begin
      if (!sim_rst_n) begin
         x_r  <= X0;
         y_r  <= Y0;
         dx_r <= 1'b1;
         dy_r <= 1'b1;
      end else if (tick && !pause) begin
         x_r  <= x_step_s[CORDW-1:0];
         dx_r <= x_step_s[CORDW];
         y_r  <= y_step_s[CORDW-1:0];
         dy_r <= y_step_s[CORDW];
      end else begin
         x_r  <= x_r;
         y_r  <= y_r;
         dx_r <= dx_r;
         dy_r <= dy_r;
      end
   end

endmodule

// File: rtl/top_bounce.sv
// Bouncing-squares demo: raster counters, N_SQ square movers and a
// registered colour stage that paints the lowest-index hit square.
module top_bounce
   import bounce_pkg::*;
#(
   parameter int CORDW   = 10,
   parameter int N_SQ    = 4,
   parameter int SQ_SIZE = 40,
   parameter int SPEED   = 2
) (
   input  logic     clk_pix,
   input  logic     sim_rst_n,
   bounce_if.master vid
);

   localparam logic [CORDW-1:0] SX_MAX = CORDW'(LINE - 1);
   localparam logic [CORDW-1:0] SY_MAX = CORDW'(SCREEN - 1);
   localparam logic [CORDW-1:0] H_END  = CORDW'(H_RES);
   localparam logic [CORDW-1:0] V_END  = CORDW'(V_RES);
   localparam logic [CORDW-1:0] ONE_C  = {{(CORDW-1){1'b0}}, 1'b1};

   logic [CORDW-1:0] sx_r;
   logic [CORDW-1:0] sy_r;
   logic             tick_s;
   logic             de_s;
   logic [N_SQ-1:0]  hit_s;
   rgb4_t            colour_s;

   // Raster counters: sx sweeps the line, sy advances when sx wraps.
   always_ff @(posedge clk_pix) begin
      if (!sim_rst_n) begin
         sx_r <= '0;
         sy_r <= '0;
      end else if (sx_r == SX_MAX) begin
         sx_r <= '0;
         if (sy_r == SY_MAX) begin
            sy_r <= '0;
         end else begin
            sy_r <= sy_r + ONE_C;
         end
      end else begin
         sx_r <= sx_r + ONE_C;
         sy_r <= sy_r;
      end
   end

   // The tick falls at the start of vertical blanking, so motion never tears.
   always_comb begin
      tick_s = (sx_r == '0) && (sy_r == V_END);
      de_s   = (sx_r < H_END) && (sy_r < V_END);
   end

   for (genvar i = 0; i < N_SQ; i++) begin : g_sq
      square_mover #(
         .CORDW   (CORDW),
         .SQ_SIZE (SQ_SIZE),
         .SPEED   (SPEED),
         .INIT_X  (INIT_X[i]),
         .INIT_Y  (INIT_Y[i])
      ) u_sq (
         .clk_pix   (clk_pix),
         .sim_rst_n (sim_rst_n),
         .tick      (tick_s),
         .pause     (vid.pause),
         .sx        (sx_r),
         .sy        (sy_r),
         .hit       (hit_s[i])
      );
   end

   // Walk from highest to lowest index so square 0 has final say.
   always_comb begin
      colour_s = BG_COLOUR;
      for (int i = N_SQ - 1; i >= 0; i--) begin
         if (hit_s[i]) begin
            colour_s = COLOUR[i];
         end else begin
            colour_s = colour_s;
         end
      end
   end

   // Output stage; colour is deliberately left unmasked by de.
   always_ff @(posedge clk_pix) begin
      if (!sim_rst_n) begin
         vid.sdl_sx <= '0;
         vid.sdl_sy <= '0;
         vid.sdl_de <= 1'b0;
         vid.sdl_r  <= 8'h00;
         vid.sdl_g  <= 8'h00;
         vid.sdl_b  <= 8'h00;
         vid.frame  <= 1'b0;
      end else begin
         vid.sdl_sx <= sx_r;
         vid.sdl_sy <= sy_r;
         vid.sdl_de <= de_s;
         vid.sdl_r  <= dbl4(colour_s.r);
         vid.sdl_g  <= dbl4(colour_s.g);
         vid.sdl_b  <= dbl4(colour_s.b);
         vid.frame  <= tick_s;
      end
   end

endmodule

// File: tb/tb_top_bounce.sv
// Bench for top_bounce: directed scenarios plus randomized jumps, checked
// every cycle against a behavioural raster/square model.
module tb_top_bounce;

   localparam int CORDW   = 10;
   localparam int N_SQ    = 4;
   localparam int SQ_SIZE = 40;
   localparam int SPEED   = 2;
   localparam int XS [4]  = '{40, 160, 280, 400};
   localparam int YS [4]  = '{40, 120, 200, 280};
   localparam int CS [4]  = '{'hF00, 'h0F0, 'h00F, 'hFF0};

   logic clk_pix   = 1'b0;
   logic sim_rst_n = 1'b0;

   bounce_if #(.CORDW(CORDW)) vid ();

   top_bounce #(
      .CORDW   (CORDW),
      .N_SQ    (N_SQ),
      .SQ_SIZE (SQ_SIZE),
      .SPEED   (SPEED)
   ) dut (
      .clk_pix   (clk_pix),
      .sim_rst_n (sim_rst_n),
      .vid       (vid)
   );

   always #5 clk_pix = ~clk_pix;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int m_sx, m_sy;
   int m_x [4];
   int m_y [4];
   bit m_dx [4];
   bit m_dy [4];
   int e_sx, e_sy, e_de, e_r, e_g, e_b, e_frame;

   logic [9:0] f_sx, f_sy, f_x, f_y;
   logic       f_dx, f_dy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bounce(inout int p, inout bit d, input int lim);
      if (d) begin
         if (p + SPEED >= lim) begin p = lim; d = 1'b0; end
         else p = p + SPEED;
      end else begin
         if (p <= SPEED) begin p = 0; d = 1'b1; end
         else p = p - SPEED;
      end
   endtask

   function automatic int pix(input int x, input int y);
      for (int i = 0; i < N_SQ; i++)
         if (x >= m_x[i] && x < m_x[i] + SQ_SIZE && y >= m_y[i] && y < m_y[i] + SQ_SIZE)
            return CS[i];
      return 'h137;
   endfunction

   // What one clock edge does, seen from outside.
   task automatic model_edge();
      int c;
      bit tk;
      if (!sim_rst_n) begin
         m_sx = 0; m_sy = 0;
         e_sx = 0; e_sy = 0; e_de = 0; e_r = 0; e_g = 0; e_b = 0; e_frame = 0;
         for (int i = 0; i < 4; i++) begin
            m_x[i] = XS[i]; m_y[i] = YS[i]; m_dx[i] = 1'b1; m_dy[i] = 1'b1;
         end
      end else begin
         c = pix(m_sx, m_sy);
         e_sx = m_sx; e_sy = m_sy;
         e_de = (m_sx < 640 && m_sy < 480) ? 1 : 0;
         e_r = ((c >> 8) & 15) * 17;
         e_g = ((c >> 4) & 15) * 17;
         e_b = (c & 15) * 17;
         tk = (m_sx == 0 && m_sy == 480);
         e_frame = tk ? 1 : 0;
         if (tk && !vid.pause)
            for (int i = 0; i < N_SQ; i++) begin
               bounce(m_x[i], m_dx[i], 640 - SQ_SIZE);
               bounce(m_y[i], m_dy[i], 480 - SQ_SIZE);
            end
         m_sx++;
         if (m_sx == 800) begin
            m_sx = 0;
            m_sy = (m_sy == 524) ? 0 : m_sy + 1;
         end
      end
   endtask

   task automatic check_out();
      check("sdl_sx", 32'(vid.sdl_sx), e_sx);
      check("sdl_sy", 32'(vid.sdl_sy), e_sy);
      check("sdl_de", 32'(vid.sdl_de), e_de);
      check("sdl_r",  32'(vid.sdl_r),  e_r);
      check("sdl_g",  32'(vid.sdl_g),  e_g);
      check("sdl_b",  32'(vid.sdl_b),  e_b);
      check("frame",  32'(vid.frame),  e_frame);
   endtask

   task automatic check_sq();
      check("sq0_x",  32'(dut.g_sq[0].u_sq.x_r),  m_x[0]);
      check("sq0_y",  32'(dut.g_sq[0].u_sq.y_r),  m_y[0]);
      check("sq0_dx", 32'(dut.g_sq[0].u_sq.dx_r), 32'(m_dx[0]));
      check("sq0_dy", 32'(dut.g_sq[0].u_sq.dy_r), 32'(m_dy[0]));
      check("sq1_x",  32'(dut.g_sq[1].u_sq.x_r),  m_x[1]);
      check("sq1_y",  32'(dut.g_sq[1].u_sq.y_r),  m_y[1]);
      check("sq1_dx", 32'(dut.g_sq[1].u_sq.dx_r), 32'(m_dx[1]));
      check("sq1_dy", 32'(dut.g_sq[1].u_sq.dy_r), 32'(m_dy[1]));
      check("sq2_x",  32'(dut.g_sq[2].u_sq.x_r),  m_x[2]);
      check("sq2_y",  32'(dut.g_sq[2].u_sq.y_r),  m_y[2]);
      check("sq3_x",  32'(dut.g_sq[3].u_sq.x_r),  m_x[3]);
      check("sq3_y",  32'(dut.g_sq[3].u_sq.y_r),  m_y[3]);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_pix);
         model_edge();
         @(negedge clk_pix);
         check_out();
      end
   endtask

   // Teleport the raster counters (called on a falling edge).
   task automatic jump(input int x, input int y);
      f_sx = 10'(x);
      f_sy = 10'(y);
      force dut.sx_r = f_sx;
      force dut.sy_r = f_sy;
      #1;
      release dut.sx_r;
      release dut.sy_r;
      m_sx = x;
      m_sy = y;
   endtask

   task automatic set_sq(input int i, input int x, input int y, input bit dx, input bit dy);
      f_x = 10'(x); f_y = 10'(y); f_dx = dx; f_dy = dy;
      if (i == 0) begin
         force dut.g_sq[0].u_sq.x_r  = f_x;
         force dut.g_sq[0].u_sq.y_r  = f_y;
         force dut.g_sq[0].u_sq.dx_r = f_dx;
         force dut.g_sq[0].u_sq.dy_r = f_dy;
         #1;
         release dut.g_sq[0].u_sq.x_r;
         release dut.g_sq[0].u_sq.y_r;
         release dut.g_sq[0].u_sq.dx_r;
         release dut.g_sq[0].u_sq.dy_r;
      end else begin
         force dut.g_sq[1].u_sq.x_r  = f_x;
         force dut.g_sq[1].u_sq.y_r  = f_y;
         force dut.g_sq[1].u_sq.dx_r = f_dx;
         force dut.g_sq[1].u_sq.dy_r = f_dy;
         #1;
         release dut.g_sq[1].u_sq.x_r;
         release dut.g_sq[1].u_sq.y_r;
         release dut.g_sq[1].u_sq.dx_r;
         release dut.g_sq[1].u_sq.dy_r;
      end
      m_x[i] = x; m_y[i] = y; m_dx[i] = dx; m_dy[i] = dy;
   endtask

   int sel;

   initial begin
      vid.pause = 1'b0;
      sim_rst_n = 1'b0;
      run(3);
      check_sq();
      sim_rst_n = 1'b1;
      run(4);

      // First visible pixels of square 0 and its left neighbour
      jump(30, 40);
      run(10);
      check("p39_sx", 32'(vid.sdl_sx), 32'd39);
      check("p39_r", 32'(vid.sdl_r), 32'h11);
      check("p39_g", 32'(vid.sdl_g), 32'h33);
      check("p39_b", 32'(vid.sdl_b), 32'h77);
      run(1);
      check("p40_r", 32'(vid.sdl_r), 32'hFF);
      check("p40_g", 32'(vid.sdl_g), 32'h00);
      check("p40_b", 32'(vid.sdl_b), 32'h00);

      // Unpaused tick then paused tick
      jump(798, 479);
      run(3);
      check("tick_frame", 32'(vid.frame), 32'd1);
      check("tick_x", 32'(dut.g_sq[0].u_sq.x_r), 32'd42);
      check("tick_y", 32'(dut.g_sq[0].u_sq.y_r), 32'd42);
      run(1);
      check("frame_low", 32'(vid.frame), 32'd0);
      vid.pause = 1'b1;
      jump(798, 479);
      run(4);
      check("pause_x", 32'(dut.g_sq[0].u_sq.x_r), 32'd42);
      check("pause_y", 32'(dut.g_sq[0].u_sq.y_r), 32'd42);
      vid.pause = 1'b0;

      // Right wall
      set_sq(0, 598, 42, 1'b1, 1'b1);
      jump(798, 479); run(3);
      check("rwall_x", 32'(dut.g_sq[0].u_sq.x_r), 32'd600);
      check("rwall_dx", 32'(dut.g_sq[0].u_sq.dx_r), 32'd0);
      jump(798, 479); run(3);
      check("rwall_back", 32'(dut.g_sq[0].u_sq.x_r), 32'd598);

      // Left wall
      set_sq(0, 1, 42, 1'b0, 1'b1);
      jump(798, 479); run(3);
      check("lwall_x", 32'(dut.g_sq[0].u_sq.x_r), 32'd0);
      check("lwall_dx", 32'(dut.g_sq[0].u_sq.dx_r), 32'd1);
      jump(798, 479); run(3);
      check("lwall_fwd", 32'(dut.g_sq[0].u_sq.x_r), 32'd2);
      check_sq();

      // Overlap: square 0 wins
      set_sq(0, 100, 100, 1'b1, 1'b1);
      set_sq(1, 100, 100, 1'b1, 1'b1);
      jump(105, 110);
      run(6);
      check("ovl_sx", 32'(vid.sdl_sx), 32'd110);
      check("ovl_r", 32'(vid.sdl_r), 32'hFF);
      check("ovl_g", 32'(vid.sdl_g), 32'h00);
      check("ovl_b", 32'(vid.sdl_b), 32'h00);

      // Randomized jumps, placements, pauses and short resets
      for (int k = 0; k < 16; k++) begin
         sel = $urandom_range(0, 3);
         if (sel == 0)
            set_sq(0, $urandom_range(0, 600), $urandom_range(0, 440), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else if (sel == 1)
            set_sq(1, $urandom_range(0, 600), $urandom_range(0, 440), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         vid.pause = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 2);
         if (sel == 0) jump(798, 479);
         else if (sel == 1) jump(m_x[0] + $urandom_range(0, 180), m_y[0] + $urandom_range(0, 40));
         else jump($urandom_range(0, 799), $urandom_range(0, 524));
         if ($urandom_range(0, 7) == 0) begin
            sim_rst_n = 1'b0; run(1); sim_rst_n = 1'b1;
         end
         run($urandom_range(4, 30));
         check_sq();
      end
      vid.pause = 1'b0;

      // Mid-frame reset
      jump(295, 200);
      run(5);
      check("pre_rst_sx", 32'(vid.sdl_sx), 32'd299);
      sim_rst_n = 1'b0;
      run(1);
      check("rst_r", 32'(vid.sdl_r), 32'd0);
      check("rst_sq0_x", 32'(dut.g_sq[0].u_sq.x_r), 32'd40);
      check_sq();
      sim_rst_n = 1'b1;
      run(1);
      check("resume_sx0", 32'(vid.sdl_sx), 32'd0);
      check("resume_sy0", 32'(vid.sdl_sy), 32'd0);
      run(1);
      check("resume_sx1", 32'(vid.sdl_sx), 32'd1);

      // Reset coinciding with a tick leaves squares at INIT
      set_sq(0, 300, 300, 1'b1, 1'b1);
      jump(0, 480);
      sim_rst_n = 1'b0;
      run(1);
      check("rst_tick_x", 32'(dut.g_sq[0].u_sq.x_r), 32'd40);
      check_sq();
      sim_rst_n = 1'b1;
      run(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/top_bounce.md
TOP_BOUNCE -- requirements
Module: top_bounce

Interface
REQ-001 Parameter CORDW, default 10, coordinate width in bits.
REQ-002 Parameter N_SQ, default 4, number of squares; legal range 1..4.
REQ-003 Parameter SQ_SIZE, default 40, square edge length in pixels.
REQ-004 Parameter SPEED, default 2, pixels moved per frame on each axis; legal range 1..SQ_SIZE.
REQ-005 Port clk_pix, input, 1, pixel clock; the only clock.
REQ-006 Port sim_rst_n, input, 1, reset, synchronous and active-low.
REQ-007 Port pause, input, 1, high freezes all square motion.
REQ-008 Port sdl_sx, output, CORDW, registered horizontal position.
REQ-009 Port sdl_sy, output, CORDW, registered vertical position.
REQ-010 Port sdl_de, output, 1, registered data enable, low in blanking.
REQ-011 Ports sdl_r, sdl_g and sdl_b, output, 8 each, registered colour channels.
REQ-012 Port frame, output, 1, one-cycle pulse on the animation tick.

Function
REQ-013 Internal counters SHALL generate sx 0..799 (wrap 799->0), with sy 0..524 incrementing when sx wraps (524->0).
REQ-014 de SHALL equal (sx<640 && sy<480).
REQ-015 The animation tick SHALL assert for exactly one cycle when sx==0 && sy==480.
REQ-016 frame SHALL be the tick delayed by one cycle, aligned with the sdl_* outputs.
REQ-017 Each square i SHALL hold state x_i, y_i (CORDW bits each) and dx_i, dy_i (1 bit each, 1 = increasing).
REQ-018 State SHALL update only on a tick with pause low; pause high on a tick leaves all state unchanged.
REQ-019 X update, dx=1: if x+SPEED >= 640-SQ_SIZE, then x <= 640-SQ_SIZE and dx <= 0; otherwise x <= x+SPEED.
REQ-020 X update, dx=0: if x <= SPEED, then x <= 0 and dx <= 1; otherwise x <= x-SPEED.
REQ-021 Y update SHALL follow REQ-019 and REQ-020 with limit 480-SQ_SIZE; the x and y axes SHALL update independently in the same cycle.
REQ-022 Arithmetic SHALL use CORDW+1 bits so that the sums cannot wrap.
REQ-023 Pixel hit for square i: x_i <= sx < x_i+SQ_SIZE and y_i <= sy < y_i+SQ_SIZE.
REQ-024 Where squares overlap, the lowest-index hit square SHALL win.
REQ-025 Painted 4-bit colour SHALL be COLOUR[i] on a hit, otherwise background 4'h1/4'h3/4'h7 (R/G/B).
REQ-026 Output SHALL be 4-bit colour doubled to 8 bits ({2{c}}).
REQ-027 Latency: sdl_sx, sdl_sy, sdl_de and sdl_r/g/b SHALL be registered one cycle after the sx/sy they describe; the colour is not masked by de.
REQ-028 Square state updated on the tick SHALL first affect the hit test on the following cycle; the tick occurs in blanking, so no visible tearing results.

Reset
REQ-029 While sim_rst_n is low at a clk_pix edge: sx=sy=0 and all sdl_* outputs and frame are 0.
REQ-030 While sim_rst_n is low at a clk_pix edge: each square takes x_i=INIT_X[i], y_i=INIT_Y[i], dx_i=dy_i=1.
REQ-031 Reset mid-frame SHALL override any tick in the same cycle; scanning restarts at (0,0) on the next cycle.

Structure
REQ-032 Package bounce_pkg SHALL hold H_RES=640, V_RES=480, LINE=800 and SCREEN=525.
REQ-033 bounce_pkg SHALL hold INIT_X={40,160,280,400}, INIT_Y={40,120,200,280} and COLOUR={F00,0F0,00F,FF0} as 4-bit RGB.
REQ-034 Sub-module square_mover SHALL hold one square's state and update logic and output its hit; top_bounce SHALL instantiate N_SQ copies via generate.

Verification
REQ-035 Reset, then scan to sx=40, sy=40 -> the next cycle gives sdl_r=FF, sdl_g=00, sdl_b=00; pixel (39,40) -> 11/33/77.
REQ-036 One tick with pause=0 -> square 0 at (42,42) and frame high for one cycle; a further tick with pause=1 -> square 0 still at (42,42).
REQ-037 Force square 0 to x=598, dx=1 -> after the tick x=600, dx=0; after the next tick x=598.
REQ-038 Force square 0 to x=1, dx=0 -> after the tick x=0, dx=1; after the next tick x=2.
REQ-039 Place squares 0 and 1 both at (100,100) -> pixel (110,110) shows COLOUR[0] (FF/00/00).
REQ-040 Assert sim_rst_n=0 at sx=300, sy=200 -> the next cycle gives all outputs 0 and square state at INIT; counting resumes from (0,0).
